// File: rtl/axi4_lite_addr_map_package.sv
// Shared AXI4-Lite constants, response codes and core access sizes.
package axi4_lite_addr_map_package;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } mem_size_e;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
interface axi4_lite_if;
  import axi4_lite_addr_map_package::*;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_lsu_align.sv
// Store lane replication/strobes, load lane extraction/extension,
// and misalignment detection for the core load/store port.
module axi4_lite_lsu_align
  import axi4_lite_addr_map_package::*;
(
  input  logic [1:0]            i_st_addr,
  input  mem_size_e             i_st_size,
  input  logic [DATA_WIDTH-1:0] i_st_wdata,
  output logic [DATA_WIDTH-1:0] o_st_wdata,
  output logic [3:0]            o_st_wstrb,
  output logic                  o_misaligned,
  input  logic [1:0]            i_ld_addr,
  input  mem_size_e             i_ld_size,
  input  logic                  i_ld_unsigned,
  input  logic [DATA_WIDTH-1:0] i_ld_rdata,
  output logic [DATA_WIDTH-1:0] o_ld_data
);

  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_sx;

  always_comb begin
    o_st_wdata   = '0;
    o_st_wstrb   = '0;
    o_misaligned = 1'b0;
    unique case (i_st_size)
      SZ_BYTE: begin
        o_st_wdata = {4{i_st_wdata[7:0]}};
        o_st_wstrb = 4'b0001 << i_st_addr;
      end
      SZ_HALF: begin
        o_st_wdata   = {2{i_st_wdata[15:0]}};
        o_st_wstrb   = 4'b0011 << i_st_addr;
        o_misaligned = i_st_addr[0];
      end
      SZ_WORD: begin
        o_st_wdata   = i_st_wdata;
        o_st_wstrb   = 4'b1111;
        o_misaligned = |i_st_addr;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign w_shift = i_ld_rdata >> {i_ld_addr, 3'b000};
  assign w_sx    = ~i_ld_unsigned;

  always_comb begin
    o_ld_data = '0;
    unique case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{w_sx & w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: o_ld_data = {{16{w_sx & w_shift[15]}}, w_shift[15:0]};
      SZ_WORD: o_ld_data = i_ld_rdata;
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/axi4_lite_master_bridge.sv
// Core load/store port to AXI4-Lite master, one outstanding access.
// Every core and bus output comes straight from a register.
module axi4_lite_master_bridge
  import axi4_lite_addr_map_package::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_done,
  output logic                  mem_err,
  output logic                  mem_busy,
  axi4_lite_if.master           m_axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  awvalid;
    logic                  wvalid;
    logic                  bready;
    logic                  arvalid;
    logic                  rready;
    logic                  aw_done;
    logic                  w_done;
    logic [1:0]            addr_lo;
    mem_size_e             size;
    logic                  uns;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  done;
    logic                  err;
    logic                  busy;
  } regs_t;

  state_e                r_state;
  state_e                w_state_nxt;
  regs_t                 r_q;
  regs_t                 w_d;
  logic [DATA_WIDTH-1:0] w_st_wdata;
  logic [3:0]            w_st_wstrb;
  logic                  w_misaligned;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [ADDR_WIDTH-1:0] w_bus_addr;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_err;
  logic                  w_r_err;

  axi4_lite_lsu_align u_align (
    .i_st_addr     (mem_addr[1:0]),
    .i_st_size     (mem_size_e'(mem_size)),
    .i_st_wdata    (mem_wdata),
    .o_st_wdata    (w_st_wdata),
    .o_st_wstrb    (w_st_wstrb),
    .o_misaligned  (w_misaligned),
    .i_ld_addr     (r_q.addr_lo),
    .i_ld_size     (r_q.size),
    .i_ld_unsigned (r_q.uns),
    .i_ld_rdata    (m_axi.rdata),
    .o_ld_data     (w_ld_data)
  );

  assign w_bus_addr = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_aw_hs    = r_q.awvalid & m_axi.awready;
  assign w_w_hs     = r_q.wvalid & m_axi.wready;
  assign w_b_err    = (m_axi.bresp == RESP_SLVERR) |
                      (m_axi.bresp == RESP_DECERR);
  assign w_r_err    = (m_axi.rresp == RESP_SLVERR) |
                      (m_axi.rresp == RESP_DECERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_d;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_d         = r_q;
    unique case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          w_d.addr_lo = mem_addr[1:0];
          w_d.size    = mem_size_e'(mem_size);
          w_d.uns     = mem_unsigned;
          w_d.wdata   = w_st_wdata;
          w_d.wstrb   = w_st_wstrb;
          w_d.awaddr  = w_bus_addr;
          w_d.araddr  = w_bus_addr;
          w_d.rdata   = '0;
          w_d.err     = 1'b0;
          w_d.aw_done = 1'b0;
          w_d.w_done  = 1'b0;
          if (w_misaligned) begin
            w_state_nxt = S_DONE;
            w_d.done    = 1'b1;
            w_d.err     = 1'b1;
          end else if (mem_we) begin
            w_state_nxt = S_WR;
            w_d.awvalid = 1'b1;
            w_d.wvalid  = 1'b1;
          end else begin
            w_state_nxt = S_RD_ADDR;
            w_d.arvalid = 1'b1;
          end
        end
      end
      S_WR: begin
        // AW and W retire independently; wait for both.
        if (w_aw_hs) begin
          w_d.awvalid = 1'b0;
          w_d.aw_done = 1'b1;
        end
        if (w_w_hs) begin
          w_d.wvalid = 1'b0;
          w_d.w_done = 1'b1;
        end
        if (w_d.aw_done && w_d.w_done) begin
          w_state_nxt = S_WR_RESP;
          w_d.bready  = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axi.bvalid) begin
          w_state_nxt = S_DONE;
          w_d.bready  = 1'b0;
          w_d.err     = w_b_err;
          w_d.done    = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (m_axi.arready) begin
          w_state_nxt = S_RD_DATA;
          w_d.arvalid = 1'b0;
          w_d.rready  = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (m_axi.rvalid) begin
          w_state_nxt = S_DONE;
          w_d.rready  = 1'b0;
          w_d.err     = w_r_err;
          w_d.rdata   = w_r_err ? '0 : w_ld_data;
          w_d.done    = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_d.done    = 1'b0;
        w_d.err     = 1'b0;
        w_d.rdata   = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_d.busy = (w_state_nxt != S_IDLE);
  end

  assign m_axi.awaddr  = r_q.awaddr;
  assign m_axi.awvalid = r_q.awvalid;
  assign m_axi.wdata   = r_q.wdata;
  assign m_axi.wstrb   = r_q.wstrb;
  assign m_axi.wvalid  = r_q.wvalid;
  assign m_axi.bready  = r_q.bready;
  assign m_axi.araddr  = r_q.araddr;
  assign m_axi.arvalid = r_q.arvalid;
  assign m_axi.rready  = r_q.rready;

  assign mem_rdata = r_q.rdata;
  assign mem_done  = r_q.done;
  assign mem_err   = r_q.err;
  assign mem_busy  = r_q.busy;

endmodule
